// File: rtl/j1_wb_pkg.sv
// ============================================================================
// Module  : j1_wb_pkg
// Brief   : Shared types and constants for the J1 instruction/data Wishbone
//           arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package j1_wb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  // The timeout counter is sized for the full 1..255 range.
  localparam int unsigned CNT_W = 8;

endpackage : j1_wb_pkg

`default_nettype wire

// File: rtl/j1_wb_arbiter_if.sv
// ============================================================================
// Module  : j1_wb_arbiter_if
// Brief   : Requester and Wishbone bundle seen by the J1 arbiter; the master
//           modport is the arbiter view, the slave modport the environment.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface j1_wb_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);

  // Instruction-fetch port
  logic          i_req;
  logic [AW-1:0] i_adr;
  logic          i_ack;
  logic          i_err;
  logic [DW-1:0] i_dat;

  // Data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_adr;
  logic [DW-1:0] d_dat_w;
  logic          d_ack;
  logic          d_err;
  logic [DW-1:0] d_dat_r;

  // Wishbone master port
  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack;
  logic          wb_err;

  modport master (
    input  i_req, i_adr,
    output i_ack, i_err, i_dat,
    input  d_req, d_we, d_adr, d_dat_w,
    output d_ack, d_err, d_dat_r,
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    input  wb_dat_i, wb_ack, wb_err
  );

  modport slave (
    output i_req, i_adr,
    input  i_ack, i_err, i_dat,
    output d_req, d_we, d_adr, d_dat_w,
    input  d_ack, d_err, d_dat_r,
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    output wb_dat_i, wb_ack, wb_err
  );

endinterface : j1_wb_arbiter_if

`default_nettype wire

// File: rtl/j1_wb_rr.sv
// ============================================================================
// Module  : j1_wb_rr
// Brief   : Two-way round-robin pick between instruction and data requests.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module j1_wb_rr
  import j1_wb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_t last,
  output owner_t grant
);

  // On a tie the side that did not win last time goes next. With no request
  // the output is don't-care; the caller only samples it when a request exists.
  always_comb begin
    grant = OWN_INSTR;
    if (d_req && (!i_req || (last == OWN_INSTR))) begin
      grant = OWN_DATA;
    end
  end

endmodule : j1_wb_rr

`default_nettype wire

// File: rtl/j1_wb_arbiter.sv
// ============================================================================
// Module  : j1_wb_arbiter
// Brief   : Shares one Wishbone master between J1 instruction fetch and data
//           ports, with round-robin on ties and a no-ack timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module j1_wb_arbiter
  import j1_wb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = int'(TIMEOUT_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  j1_wb_arbiter_if.master   bus
);

  localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q;
  owner_t            owner_q;
  owner_t            last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              wb_cyc_q;
  logic              wb_we_q;
  logic [AW-1:0]     wb_adr_q;
  logic [DW-1:0]     wb_dat_o_q;

  logic              i_ack_q;
  logic              i_err_q;
  logic [DW-1:0]     i_dat_q;
  logic              d_ack_q;
  logic              d_err_q;
  logic [DW-1:0]     d_dat_r_q;

  owner_t            w_grant;
  logic              w_any_req;
  logic              w_timeout;
  logic              w_done;
  logic              w_abort;
  logic [DW-1:0]     w_rsp_dat;

  j1_wb_rr u_rr (
    .i_req (bus.i_req),
    .d_req (bus.d_req),
    .last  (last_q),
    .grant (w_grant)
  );

  // A transaction ends on ack, error or timeout; anything but a clean ack
  // (error wins over a simultaneous ack) is reported as an abort with zero data.
  always_comb begin
    cnt_d     = cnt_q + CNT_W'(1);
    w_any_req = bus.i_req | bus.d_req;
    w_timeout = (cnt_q == C_TO_LAST);
    w_done    = bus.wb_ack | bus.wb_err | w_timeout;
    w_abort   = bus.wb_err | ~bus.wb_ack;
    w_rsp_dat = w_abort ? '0 : bus.wb_dat_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_INSTR;
      last_q     <= OWN_INSTR;
      cnt_q      <= '0;
      wb_cyc_q   <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_adr_q   <= '0;
      wb_dat_o_q <= '0;
      i_ack_q    <= 1'b0;
      i_err_q    <= 1'b0;
      i_dat_q    <= '0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      d_dat_r_q  <= '0;
    end else begin
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (w_any_req) begin
            state_q  <= ST_BUSY;
            owner_q  <= w_grant;
            last_q   <= w_grant;
            cnt_q    <= '0;
            wb_cyc_q <= 1'b1;
            if (w_grant == OWN_DATA) begin
              wb_we_q    <= bus.d_we;
              wb_adr_q   <= bus.d_adr;
              wb_dat_o_q <= bus.d_dat_w;
            end else begin
              wb_we_q    <= 1'b0;
              wb_adr_q   <= bus.i_adr;
              wb_dat_o_q <= '0;
            end
          end
        end

        ST_BUSY: begin
          if (w_done) begin
            state_q  <= ST_IDLE;
            wb_cyc_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_ack_q   <= 1'b1;
              d_err_q   <= w_abort;
              d_dat_r_q <= w_rsp_dat;
            end else begin
              i_ack_q <= 1'b1;
              i_err_q <= w_abort;
              i_dat_q <= w_rsp_dat;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q  <= ST_IDLE;
          wb_cyc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wb_cyc   = wb_cyc_q;
  assign bus.wb_stb   = wb_cyc_q;
  assign bus.wb_we    = wb_we_q;
  assign bus.wb_adr   = wb_adr_q;
  assign bus.wb_dat_o = wb_dat_o_q;

  assign bus.i_ack    = i_ack_q;
  assign bus.i_err    = i_err_q;
  assign bus.i_dat    = i_dat_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_dat_r  = d_dat_r_q;

  a_one_ack : assert property (@(posedge clk) disable iff (reset)
    !(i_ack_q && d_ack_q));

  a_ack_idle : assert property (@(posedge clk) disable iff (reset)
    (i_ack_q || d_ack_q) |-> (state_q == ST_IDLE));

endmodule : j1_wb_arbiter

`default_nettype wire

// File: tb/tb_j1_wb_arbiter.sv
// ============================================================================
// Module  : tb_j1_wb_arbiter
// Brief   : Scoreboard bench for j1_wb_arbiter with a configurable slave.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_j1_wb_arbiter;
  import j1_wb_pkg::*;

  typedef struct {
    logic [15:0] adr;
    logic        we;
    logic [15:0] dat;
    int          nb;       // expected BUSY length, 0 = abandoned by reset
  } bus_t;

  typedef struct {
    owner_t      owner;
    logic        err;
    logic [15:0] dat;
    int          ack_cyc;  // expected cycle of the ack, -1 = unchecked
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  j1_wb_arbiter_if #(.AW(16), .DW(16)) bus ();

  j1_wb_arbiter #(.AW(16), .DW(16), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  bus_t bus_q[$];
  rsp_t rsp_q[$];
  logic [15:0] exp_i_dat = 16'h0;
  logic [15:0] exp_d_dat = 16'h0;

  int          slv_wait = 0;
  int          slv_mode = 0;   // 0 ack, 1 err, 2 err+ack, 3 silent
  logic [15:0] slv_data = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  // Wishbone slave: responds in BUSY cycle slv_wait+1
  initial begin
    int k;
    k = 0;
    bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0;
    bus.wb_dat_i = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (bus.wb_stb && !reset) begin
        k++;
        if (k == slv_wait + 1 && slv_mode != 3) begin
          bus.wb_ack = (slv_mode != 1);
          bus.wb_err = (slv_mode != 0);
          bus.wb_dat_i = slv_data;
        end else begin
          bus.wb_ack = 1'b0;
          bus.wb_err = 1'b0;
          bus.wb_dat_i = 16'hDEAD;
        end
      end else begin
        k = 0;
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        bus.wb_dat_i = 16'hDEAD;
      end
    end
  end

  // Bus monitor: payload stable through BUSY and BUSY length
  initial begin
    bus_t cur;
    bit   cur_v;
    int   len;
    cur_v = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus.wb_stb && !cur_v) begin
        if (bus_q.size() == 0) begin
          check("unexpected_stb", 32'(bus.wb_adr), 32'hFFFF_FFFF);
          cur = '{adr: bus.wb_adr, we: bus.wb_we, dat: bus.wb_dat_o, nb: 0};
        end else begin
          cur = bus_q.pop_front();
        end
        cur_v = 1;
        len = 0;
      end
      if (bus.wb_stb) begin
        len++;
        check("wb_adr", 32'(bus.wb_adr), 32'(cur.adr));
        check("wb_we", 32'(bus.wb_we), 32'(cur.we));
        check("wb_dat_o", 32'(bus.wb_dat_o), 32'(cur.dat));
        check("wb_cyc_eq_stb", 32'(bus.wb_cyc), 32'(bus.wb_stb));
      end else if (cur_v) begin
        if (cur.nb != 0) check("busy_len", 32'(len), 32'(cur.nb));
        cur_v = 0;
      end
    end
  end

  // Response monitor
  initial forever begin
    rsp_t r;
    @(negedge clk);
    if (bus.i_ack || bus.d_ack) begin
      check("single_ack", 32'(bus.i_ack & bus.d_ack), 32'h0);
      if (rsp_q.size() == 0) begin
        check("unexpected_ack", {30'h0, bus.d_ack, bus.i_ack}, 32'h0);
      end else begin
        r = rsp_q.pop_front();
        check("ack_owner", 32'(bus.d_ack), 32'(r.owner == OWN_DATA));
        if (r.ack_cyc >= 0) check("ack_latency", 32'(cyc_n), 32'(r.ack_cyc));
        if (r.owner == OWN_DATA) begin
          check("d_err", 32'(bus.d_err), 32'(r.err));
          check("d_dat_r", 32'(bus.d_dat_r), 32'(r.dat));
          check("i_dat_hold", 32'(bus.i_dat), 32'(exp_i_dat));
          exp_d_dat = r.dat;
        end else begin
          check("i_err", 32'(bus.i_err), 32'(r.err));
          check("i_dat", 32'(bus.i_dat), 32'(r.dat));
          check("d_dat_hold", 32'(bus.d_dat_r), 32'(exp_d_dat));
          exp_i_dat = r.dat;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_i_dat = 16'h0;
    exp_d_dat = 16'h0;
    @(negedge clk);
    check("rst_wb_cyc", 32'(bus.wb_cyc), 32'h0);
    check("rst_wb_stb", 32'(bus.wb_stb), 32'h0);
    check("rst_wb_we", 32'(bus.wb_we), 32'h0);
    check("rst_wb_adr", 32'(bus.wb_adr), 32'h0);
    check("rst_wb_dat_o", 32'(bus.wb_dat_o), 32'h0);
    check("rst_acks", {28'h0, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 32'h0);
    check("rst_i_dat", 32'(bus.i_dat), 32'h0);
    check("rst_d_dat_r", 32'(bus.d_dat_r), 32'h0);
    reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || bus_q.size() != 0 || bus.wb_stb) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(rsp_q.size() + bus_q.size()), 32'h0);
    @(negedge clk);
  endtask

  // One-cycle request, then the payload is scrambled; returns the request cycle
  task automatic issue(input owner_t who, input logic we, input logic [15:0] adr,
                       input logic [15:0] dat, output int c);
    @(negedge clk);
    c = cyc_n;
    if (who == OWN_DATA) begin
      bus.d_req = 1'b1; bus.d_we = we; bus.d_adr = adr; bus.d_dat_w = dat;
    end else begin
      bus.i_req = 1'b1; bus.i_adr = adr;
    end
    @(negedge clk);
    bus.i_req = 1'b0; bus.i_adr = 16'hFFFF;
    bus.d_req = 1'b0; bus.d_we = ~we; bus.d_adr = 16'hFFFF; bus.d_dat_w = 16'hFFFF;
  endtask

  task automatic config_slave(input int mode, input int wt, input logic [15:0] data);
    slv_mode = mode;
    slv_wait = wt;
    slv_data = data;
  endtask

  initial begin
    int c;
    int n;
    int acks;
    bus.i_req = 1'b0; bus.i_adr = 16'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_adr = 16'h0; bus.d_dat_w = 16'h0;

    apply_reset();

    // Zero-wait fetch with latency check
    config_slave(0, 0, 16'h6A5C);
    bus_q.push_back('{adr: 16'h0010, we: 1'b0, dat: 16'h0, nb: 1});
    rsp_q.push_back('{owner: OWN_INSTR, err: 1'b0, dat: 16'h6A5C, ack_cyc: cyc_n + 1 + 2});
    issue(OWN_INSTR, 1'b0, 16'h0010, 16'h0, c);
    wait_idle();

    // Write with three wait states
    config_slave(0, 3, 16'hBEEF);
    bus_q.push_back('{adr: 16'h4000, we: 1'b1, dat: 16'h1234, nb: 4});
    rsp_q.push_back('{owner: OWN_DATA, err: 1'b0, dat: 16'hBEEF, ack_cyc: -1});
    issue(OWN_DATA, 1'b1, 16'h4000, 16'h1234, c);
    wait_idle();

    // Data read, one wait state
    config_slave(0, 1, 16'h5555);
    bus_q.push_back('{adr: 16'h0300, we: 1'b0, dat: 16'h0, nb: 2});
    rsp_q.push_back('{owner: OWN_DATA, err: 1'b0, dat: 16'h5555, ack_cyc: -1});
    issue(OWN_DATA, 1'b0, 16'h0300, 16'h0, c);
    wait_idle();

    // Error together with ack on a data read
    config_slave(2, 0, 16'h9999);
    bus_q.push_back('{adr: 16'h0400, we: 1'b0, dat: 16'h0, nb: 1});
    rsp_q.push_back('{owner: OWN_DATA, err: 1'b1, dat: 16'h0, ack_cyc: -1});
    issue(OWN_DATA, 1'b0, 16'h0400, 16'h0, c);
    wait_idle();

    // Error alone on a fetch after two wait states
    config_slave(1, 2, 16'h8888);
    bus_q.push_back('{adr: 16'h0020, we: 1'b0, dat: 16'h0, nb: 3});
    rsp_q.push_back('{owner: OWN_INSTR, err: 1'b1, dat: 16'h0, ack_cyc: -1});
    issue(OWN_INSTR, 1'b0, 16'h0020, 16'h0, c);
    wait_idle();

    // Silent slave: abort after 8 BUSY cycles
    config_slave(3, 0, 16'h7777);
    bus_q.push_back('{adr: 16'h0500, we: 1'b1, dat: 16'hCAFE, nb: 8});
    rsp_q.push_back('{owner: OWN_DATA, err: 1'b1, dat: 16'h0, ack_cyc: -1});
    issue(OWN_DATA, 1'b1, 16'h0500, 16'hCAFE, c);
    wait_idle();

    // Contention from reset: DATA, INSTR, DATA, INSTR
    apply_reset();
    config_slave(0, 0, 16'h1111);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        bus_q.push_back('{adr: 16'h0200, we: 1'b0, dat: 16'h0, nb: 1});
        rsp_q.push_back('{owner: OWN_DATA, err: 1'b0, dat: 16'h1111, ack_cyc: -1});
      end else begin
        bus_q.push_back('{adr: 16'h0100, we: 1'b0, dat: 16'h0, nb: 1});
        rsp_q.push_back('{owner: OWN_INSTR, err: 1'b0, dat: 16'h1111, ack_cyc: -1});
      end
    end
    bus.i_req = 1'b1; bus.i_adr = 16'h0100;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_adr = 16'h0200; bus.d_dat_w = 16'h0;
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.i_ack || bus.d_ack) acks++;
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    check("contention_acks", 32'(acks), 32'd4);
    wait_idle();

    // Reset in the second wait cycle of a data read
    config_slave(0, 5, 16'h4444);
    bus_q.push_back('{adr: 16'h0600, we: 1'b0, dat: 16'h0, nb: 0});
    issue(OWN_DATA, 1'b0, 16'h0600, 16'h0, c);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_i_dat = 16'h0;
    exp_d_dat = 16'h0;
    #1;
    check("async_rst_cyc", 32'(bus.wb_cyc), 32'h0);
    check("async_rst_stb", 32'(bus.wb_stb), 32'h0);
    check("async_rst_ack", 32'(bus.d_ack | bus.i_ack), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Normal grant right after reset release
    config_slave(0, 0, 16'h7777);
    bus_q.push_back('{adr: 16'h0030, we: 1'b0, dat: 16'h0, nb: 1});
    rsp_q.push_back('{owner: OWN_INSTR, err: 1'b0, dat: 16'h7777, ack_cyc: cyc_n + 1 + 2});
    issue(OWN_INSTR, 1'b0, 16'h0030, 16'h0, c);
    wait_idle();

    check("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
    check("bus_queue_empty", 32'(bus_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_j1_wb_arbiter

`default_nettype wire

// File: doc/j1_wb_arbiter.md
J1_WB_ARBITER -- requirements
Module: j1_wb_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  AW, 16, address width
  DW, 16, data width
  TIMEOUT, 255, cycles without ack before abort; range 1..255
REQ-002 Ports SHALL be, as name direction width meaning:
  clk  in  1  single clock; all logic on rising edge
  reset  in  1  asynchronous, active-high reset
  i_req  in  1  instruction-fetch request, read-only
  i_adr  in  AW  fetch address
  i_ack  out  1  fetch done, one-cycle pulse
  i_err  out  1  fetch aborted; valid with i_ack
  i_dat  out  DW  fetch data; valid with i_ack
  d_req  in  1  data request
  d_we  in  1  data write enable
  d_adr  in  AW  data address
  d_dat_w  in  DW  write data
  d_ack  out  1  data done, one-cycle pulse
  d_err  out  1  data aborted; valid with d_ack
  d_dat_r  out  DW  read data; valid with d_ack
  wb_cyc, wb_stb  out  1  Wishbone cycle and strobe, always equal
  wb_we  out  1  Wishbone write enable
  wb_adr  out  AW  Wishbone address
  wb_dat_o  out  DW  Wishbone write data
  wb_dat_i  in  DW  Wishbone read data
  wb_ack  in  1  slave acknowledge, wait states allowed
  wb_err  in  1  slave error

Function
REQ-003 FSM SHALL have states IDLE and BUSY, plus an owner register (INSTR/DATA) and a last-granted register.
REQ-004 IDLE with any request: latch the winner's adr/we/dat and owner; go to BUSY; wb_cyc/wb_stb high on the next cycle.
REQ-005 Both requests in the same IDLE cycle: grant the requester NOT last granted (round-robin); last-granted resets to INSTR, so DATA wins the first tie.
REQ-006 A fetch SHALL drive wb_we=0; wb_dat_o SHALL be 0 for fetches.
REQ-007 All wb_* outputs SHALL be registered and held stable for the whole of BUSY.
REQ-008 BUSY with wb_ack=1, single cycle:
  drop cyc/stb next cycle
  pulse the owner's ack for exactly one cycle, err=0
  register wb_dat_i onto the owner's data output
  return to IDLE
REQ-009 BUSY with wb_err=1: same as REQ-008, but err=1 and data output 0; wb_err has priority if asserted with wb_ack.
REQ-010 Timeout counter SHALL clear on entering BUSY and increment each BUSY cycle without ack/err; on reaching TIMEOUT, handle as wb_err.
REQ-011 Latency: request in IDLE cycle N -> stb at N+1; zero-wait ack at N+1 -> requester ack at N+2; next grant earliest at N+2 (stb at N+3).
REQ-012 Requester payload is sampled only at grant; requests that change or drop during BUSY SHALL NOT affect the transaction, and its ack still pulses.
REQ-013 A requester holding req after its ack SHALL be treated as a new request.
REQ-014 The non-owner's ack/err SHALL never pulse; i_ack and d_ack are never high together.
REQ-015 The i_dat and d_dat_r outputs SHALL hold their last value until that requester's next ack.

Reset
REQ-016 Asserting reset SHALL immediately force:
  state IDLE, owner INSTR, last-granted INSTR
  counter 0
  wb_cyc/stb/we 0, wb_adr 0, wb_dat_o 0
  all acks, errs and data outputs 0
REQ-017 Reset during BUSY SHALL abandon the transaction without an ack pulse.
REQ-018 After reset deasserts, the first grant occurs on the first clock edge with a request.

Structure
REQ-019 Package j1_wb_pkg SHALL hold the state enum, the owner enum and the default TIMEOUT constant.
REQ-020 Round-robin selection SHALL be a sub-module j1_wb_rr: inputs i_req, d_req, last; output grant owner; purely combinational.

Verification
REQ-021 Zero-wait: i_req, i_adr=0x0010, wb_dat_i=0x6A5C with immediate ack -> stb for 1 cycle, we=0; i_ack with i_dat=0x6A5C two cycles after the request.
REQ-022 Wait states: d_we=1, d_adr=0x4000, d_dat_w=0x1234, ack after 3 wait cycles -> adr/dat/we stable for 4 BUSY cycles; single d_ack, d_err=0.
REQ-023 Contention: i_req and d_req held high after reset -> grant order DATA, INSTR, DATA, INSTR; never two acks in one cycle.
REQ-024 Timeout: TIMEOUT=8, slave never acks -> stb drops after 8 BUSY cycles; owner ack=1, err=1, data=0.
REQ-025 Slave error: wb_err and wb_ack asserted together on a data read -> d_err=1, d_dat_r=0.
REQ-026 Reset mid-BUSY: reset during the second wait cycle -> cyc/stb low without waiting for a clock edge; no ack pulse; next request is granted normally.
